// File: rtl/sub_pkg.sv
// rtl/sub_pkg.sv - shared types and constants for the subtractor result BCD stage
package sub_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam bcd_digit_t BCD_ADJ_THRESH = 4'd5;
    localparam bcd_digit_t BCD_ADJ_ADD    = 4'd3;

    function automatic longint pow10(input int d);
        longint r;
        r = 1;
        for (int i = 0; i < d; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_adjust.sv
// rtl/bcd_adjust.sv - double-dabble digit correction: add 3 when the digit is 5 or more
module bcd_adjust
    import sub_pkg::*;
(
    input  bcd_digit_t dig_i,
    output bcd_digit_t dig_o
);

    always_comb begin
        dig_o = dig_i;
        if (dig_i >= BCD_ADJ_THRESH) begin
            dig_o = dig_i + BCD_ADJ_ADD;
        end
    end

endmodule

// File: rtl/sub_result_bcd.sv
// rtl/sub_result_bcd.sv - signed subtractor result to sign + packed BCD, one bit per clock
// Optional blank-digit output enabled by SUB_BCD_BLANK_EN.
module sub_result_bcd
    import sub_pkg::*;
#(
    parameter int N = 4,
    parameter int D = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   diff,
    input  logic           bout,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           sign,
`ifdef SUB_BCD_BLANK_EN
    output logic [D-1:0]   blank,
`endif
    output logic [4*D-1:0] bcd
);

    localparam int CW = $clog2(N + 2);

    if (pow10(D) <= (longint'(1) << N)) begin : g_bad_digits
        $fatal(1, "sub_result_bcd: D digits cannot hold 2^N");
    end

    state_t         state_q, state_d;
    logic           sign_q, sign_d;
    logic [4*D-1:0] bcd_q, bcd_d;
    logic [N:0]     mag_q, mag_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [4*D-1:0] adj_bcd;
    logic [4*D-1:0] shift_bcd;
    logic [N:0]     shift_mag;
    logic           last_shift;

    for (genvar g = 0; g < D; g++) begin : g_adj
        bcd_adjust u_adj (
            .dig_i (bcd_q[4*g +: 4]),
            .dig_o (adj_bcd[4*g +: 4])
        );
    end

    assign {shift_bcd, shift_mag} = {adj_bcd, mag_q} << 1;
    assign last_shift = (cnt_q == CW'(N));

    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        bcd_d   = bcd_q;
        mag_d   = mag_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d  = bout;
                    // Two's-complement negate; diff=0 with borrow yields 2^N in bit N.
                    mag_d   = bout ? ({1'b0, ~diff} + (N+1)'(1)) : {1'b0, diff};
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                bcd_d = shift_bcd;
                mag_d = shift_mag;
                cnt_d = cnt_q + CW'(1);
                if (last_shift) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            bcd_q   <= '0;
            mag_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            bcd_q   <= bcd_d;
            mag_q   <= mag_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef SUB_BCD_BLANK_EN
    logic [D-1:0] blank_q, blank_d;
    logic [D-1:0] blank_calc;
    logic         upper_zero;

    // Leading-zero suppression: digit i blanks only if it and everything above it is zero.
    always_comb begin
        blank_calc = '0;
        upper_zero = 1'b1;
        for (int i = D - 1; i >= 1; i--) begin
            upper_zero    = upper_zero & (shift_bcd[4*i +: 4] == 4'd0);
            blank_calc[i] = upper_zero;
        end
    end

    always_comb begin
        blank_d = blank_q;
        if (state_q == CONV && last_shift) begin
            blank_d = blank_calc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blank_q <= '0;
        end else begin
            blank_q <= blank_d;
        end
    end

    assign blank = blank_q;
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sign      = sign_q;
    assign bcd       = bcd_q;

endmodule

// File: tb/tb_sub_result_bcd.sv
// tb/tb_sub_result_bcd.sv - directed table-driven bench for sub_result_bcd (N=4, D=2)
module tb_sub_result_bcd;

    localparam int N = 4;
    localparam int D = 2;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   diff;
    logic           bout;
    logic           out_valid;
    logic           out_ready;
    logic           sign;
    logic [4*D-1:0] bcd;
`ifdef SUB_BCD_BLANK_EN
    logic [D-1:0]   blank;
`endif

    int checks;
    int failures;

    sub_result_bcd #(.N(N), .D(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .diff      (diff),
        .bout      (bout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sign      (sign),
`ifdef SUB_BCD_BLANK_EN
        .blank     (blank),
`endif
        .bcd       (bcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       b;
        logic [3:0] d;
        logic       s;
        logic [7:0] exp_bcd;
        logic [1:0] exp_blank;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic b, input logic [3:0] d);
        in_valid = 1'b1;
        bout     = b;
        diff     = d;
        tick();
        in_valid = 1'b0;
        bout     = ~b;
        diff     = ~d;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("handoff_out_valid", 32'(out_valid), 32'd0);
        check("handoff_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input bit chk_lat);
        int lat;
        start_op(v.b, v.d);
        wait_done(lat);
        if (chk_lat) check("latency", 32'(lat), 32'd5);
        check("out_valid", 32'(out_valid), 32'd1);
        check($sformatf("sign b=%0d d=%0h", v.b, v.d), 32'(sign), 32'(v.s));
        check($sformatf("bcd b=%0d d=%0h", v.b, v.d), 32'(bcd), 32'(v.exp_bcd));
`ifdef SUB_BCD_BLANK_EN
        check($sformatf("blank b=%0d d=%0h", v.b, v.d), 32'(blank), 32'(v.exp_blank));
`endif
    endtask

    function automatic vec_t model(input logic b, input logic [3:0] d);
        vec_t v;
        int   mag;
        mag         = b ? (16 - int'(d)) : int'(d);
        v.b         = b;
        v.d         = d;
        v.s         = b;
        v.exp_bcd   = {4'(mag / 10), 4'(mag % 10)};
        v.exp_blank = {(mag / 10) == 0, 1'b0};
        return v;
    endfunction

    initial begin
        vec_t v;
        int   lat;
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        diff      = '0;
        bout      = 1'b0;

        vecs.push_back('{1'b0, 4'b0011, 1'b0, 8'h03, 2'b10});
        vecs.push_back('{1'b1, 4'b1101, 1'b1, 8'h03, 2'b10});
        vecs.push_back('{1'b1, 4'b0000, 1'b1, 8'h16, 2'b00});
        vecs.push_back('{1'b0, 4'b0000, 1'b0, 8'h00, 2'b10});
        vecs.push_back('{1'b0, 4'b1111, 1'b0, 8'h15, 2'b00});
        vecs.push_back('{1'b1, 4'b0110, 1'b1, 8'h10, 2'b00});
        vecs.push_back('{1'b1, 4'b1111, 1'b1, 8'h01, 2'b10});
        vecs.push_back('{1'b0, 4'b1001, 1'b0, 8'h09, 2'b10});

        tick();
        tick();
        rst_n = 1'b1;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset sign", 32'(sign), 32'd0);
        check("reset bcd", 32'(bcd), 32'd0);
`ifdef SUB_BCD_BLANK_EN
        check("reset blank", 32'(blank), 32'd0);
`endif

        foreach (vecs[i]) begin
            run_vec(vecs[i], 1'b1);
            consume();
        end

        for (int k = 0; k < 32; k++) begin
            v = model(k[4], k[3:0]);
            run_vec(v, 1'b0);
            consume();
        end

        // Backpressure: result held, in_valid ignored while DONE.
        run_vec(vecs[4], 1'b1);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            bout     = 1'b1;
            diff     = 4'h0;
            tick();
            check("bp out_valid", 32'(out_valid), 32'd1);
            check("bp in_ready", 32'(in_ready), 32'd0);
            check("bp sign", 32'(sign), 32'd0);
            check("bp bcd", 32'(bcd), 32'h15);
        end
        in_valid = 1'b0;
        consume();
        check("bp no capture", 32'(bcd), 32'h15);
        run_vec(vecs[1], 1'b1);
        consume();

        // Reset during the second conversion cycle discards the operand.
        start_op(1'b1, 4'h0);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst in_ready", 32'(in_ready), 32'd1);
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst sign", 32'(sign), 32'd0);
        check("midrst bcd", 32'(bcd), 32'd0);
        tick();
        check("midrst idle hold", 32'(out_valid), 32'd0);
        run_vec(vecs[5], 1'b1);
        consume();

        wait_done(lat);
        check("no spurious result", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
